// File: rtl/audacq_stereo.sv
// ---------------------------------------------------------------------------
// audacq_stereo
//   I2S-style audio capture block. It generates sck/ws from a tick divider,
//   shifts in sd MSB-first for the left and right channels, and queues the
//   completed samples in a FIFO that the host drains over a simple register
//   bus (CTRL 0x0, STAT 0x4, DATA 0x8).
//
// Optional feature macro: AUDACQ_IRQ_EN
//   When it is defined, the irq port and the CTRL[15:8] watermark field exist.
//   When it is undefined, there is no irq port, the watermark reads 0 and
//   writes to it are ignored.
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   asynchronous, active-high reset
//   addr   in   register byte address (4 bits)
//   w_rb   in   1 = write, 0 = read
//   acc    in   access size; only `BUS_ACC_4B is legal
//   req    in   bus request
//   wdata  in   write data (32 bits)
//   rdata  out  registered read data, valid with resp
//   resp   out  completion, one cycle after a legal request
//   fault  out  combinational flag for an illegal request
//   sck    out  serial clock
//   ws     out  word select (0 = left, 1 = right/idle)
//   sd     in   serial data
//   irq    out  level interrupt (AUDACQ_IRQ_EN only)
// ---------------------------------------------------------------------------
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'b10
`endif

module audacq_stereo #(
    parameter int PRIMARY_DIV  = 26,
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                addr,
    input  logic                      w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] acc,
    input  logic                      req,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      resp,
    output logic                      fault,
    output logic                      sck,
    output logic                      ws,
    input  logic                      sd
`ifdef AUDACQ_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT} state_t;

    logic                    r_en, r_stereo, r_ovf;
    logic [7:0]              r_wmark;
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [LW-1:0]           r_level;
    logic [31:0]             r_mem [FIFO_DEPTH];
    logic [7:0]              r_div;
    state_t                  r_state, w_state_nxt;
    logic [5:0]              r_cnt;
    logic [6:0]              r_frame;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic                    r_push;
    logic [31:0]             r_push_data;
    logic                    r_resp;
    logic [31:0]             r_rdata;

    logic        w_addr_ok, w_valid, w_wr_ctrl, w_wr_stat, w_rd_data;
    logic        w_empty, w_full, w_pop, w_push_ok, w_ovf_set;
    logic        w_tick, w_last, w_cap, w_done;
    logic [23:0] w_al;
    logic [31:0] w_stat, w_ctrl, w_rd_val;
    logic        w_unused;

    // ---------------- bus decode ----------------
    assign w_addr_ok = (addr == 4'h0) | (addr == 4'h4) | (addr == 4'h8);
    assign fault     = req & (~w_addr_ok | (acc != `BUS_ACC_4B) | (w_rb & (addr == 4'h8)));
    assign w_valid   = req & ~fault;
    assign w_wr_ctrl = w_valid &  w_rb & (addr == 4'h0);
    assign w_wr_stat = w_valid &  w_rb & (addr == 4'h4);
    assign w_rd_data = w_valid & ~w_rb & (addr == 4'h8);

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_pop     = w_rd_data & ~w_empty;
    // When full, a simultaneous pop frees the slot the push is written into.
    assign w_push_ok = r_push & (~w_full | w_pop);
    assign w_ovf_set = r_push &  w_full & ~w_pop;

    assign w_stat = {22'b0, w_empty, r_ovf, 8'(r_level)};
    assign w_ctrl = {16'b0, r_wmark, 6'b0, r_stereo, r_en};

    always_comb begin
        w_rd_val = 32'b0;
        case (addr)
            4'h0:    w_rd_val = w_ctrl;
            4'h4:    w_rd_val = w_stat;
            4'h8:    w_rd_val = w_empty ? 32'b0 : r_mem[r_rptr];
            default: w_rd_val = 32'b0;
        endcase
    end

    assign w_unused = &{1'b0, wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp  <= 1'b0;
            r_rdata <= 32'b0;
        end else begin
            r_resp <= w_valid;
            if (w_valid) r_rdata <= w_rb ? 32'b0 : w_rd_val;
        end
    end

    assign resp  = r_resp;
    assign rdata = r_rdata;

    // ---------------- control registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_stereo <= 1'b0;
            r_wmark  <= 8'b0;
        end else if (w_wr_ctrl) begin
            r_en     <= wdata[0];
            r_stereo <= wdata[1];
`ifdef AUDACQ_IRQ_EN
            r_wmark  <= wdata[15:8];
`endif
        end
    end

    // ---------------- tick divider ----------------
    assign w_tick = r_en & (r_div == 8'(PRIMARY_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_div <= 8'b0;
        else if (!r_en || w_tick)  r_div <= 8'b0;
        else                       r_div <= r_div + 8'd1;
    end

    // ---------------- frame FSM ----------------
    assign w_last = w_tick & (r_cnt == 6'd63);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_state <= S_IDLE;
        else if (!r_en) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_last) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_LEFT;
                S_LEFT:  w_state_nxt = S_RIGHT;
                S_RIGHT: w_state_nxt = S_LEFT;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are gated with EN so they idle high in the same cycle EN drops.
    always_comb begin
        sck = 1'b1;
        ws  = 1'b1;
        if (r_en && (r_state != S_IDLE)) begin
            sck = r_cnt[0];
            ws  = (r_state == S_RIGHT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 6'b0;
            r_frame <= 7'b0;
            r_push  <= 1'b0;
        end else begin
            if (!r_en)       r_cnt <= 6'b0;
            else if (w_tick) r_cnt <= r_cnt + 6'd1;
            if (w_last && (r_state == S_RIGHT)) r_frame <= r_frame + 7'd1;
            r_push <= w_done;
        end
    end

    // ---------------- capture datapath ----------------
    // Exactly SAMPLE_WIDTH shifts happen per channel slot, so stale bits from
    // an aborted slot are always shifted out before the next sample completes.
    assign w_cap  = w_tick & (r_state != S_IDLE) & ~r_cnt[0] & (r_cnt != 6'd0)
                  & (r_cnt <= 6'(2 * SAMPLE_WIDTH));
    assign w_done = w_last & ((r_state == S_LEFT) | ((r_state == S_RIGHT) & r_stereo));
    assign w_al   = 24'({r_shift, 24'b0} >> SAMPLE_WIDTH);

    always_ff @(posedge clk) begin
        if (w_cap)  r_shift     <= {r_shift[SAMPLE_WIDTH-2:0], sd};
        if (w_done) r_push_data <= {(r_state == S_RIGHT), r_frame, w_al};
        if (w_push_ok) r_mem[r_wptr] <= r_push_data;
    end

    // ---------------- FIFO control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_ovf_set)                  r_ovf <= 1'b1;
            else if (w_wr_stat && wdata[8]) r_ovf <= 1'b0;
        end
    end

`ifdef AUDACQ_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= r_ovf | ((r_wmark != 8'd0) & (8'(r_level) >= r_wmark));
    end
    assign irq = r_irq;
`endif

endmodule

// File: doc/audacq_stereo.md
AUDACQ_STEREO -- requirements
Module: audacq_stereo

Interface
REQ-001 SHALL have parameter PRIMARY_DIV, default 26: clk cycles per tick, range 2..255.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24: captured bits per channel, range 16..24.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: sample entries, power of two, range 4..128.
REQ-004 SHALL have port clk  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port addr  in  4  register byte address.
REQ-007 SHALL have ports w_rb in 1 write/read-bar; acc in `BUS_ACC_WIDTH access size; req in 1 request; wdata in 32.
REQ-008 SHALL have ports rdata out 32 read data; resp out 1 completion; fault out 1 invalid request.
REQ-009 SHALL have ports sck out 1 serial clock; ws out 1 word select; sd in 1 serial data.
REQ-010 SHALL have port irq out 1 level interrupt, present only under AUDACQ_IRQ_EN.

Function
REQ-011 Register map: CTRL 0x0 RW, STAT 0x4 RW (W1C), DATA 0x8 RO (pop).
REQ-012 CTRL: [0] EN, [1] STEREO (1 push L and R, 0 push L only), [15:8] WMARK, other bits read 0.
REQ-013 STAT: [7:0] FIFO level, [8] OVF sticky, cleared by writing 1 to bit 8; [9] EMPTY.
REQ-014 DATA read: [31] channel (0 L, 1 R), [30:24] 7-bit frame counter, [23:0] sample left-aligned, unused LSBs 0; pops one entry.
REQ-015 DATA read while FIFO empty SHALL return 0 and not pop.
REQ-016 fault SHALL be combinational: req & (addr not in {0,4,8} | acc != `BUS_ACC_4B | write to DATA).
REQ-017 resp SHALL assert exactly 1 cycle after a valid req; rdata registered and valid with resp; faulted req gives no resp and no side effect.
REQ-018 Tick SHALL pulse once every PRIMARY_DIV clk cycles while EN=1; divider held at 0 while EN=0.
REQ-019 FSM states IDLE, LEFT, RIGHT; IDLE->LEFT after 64 ticks; LEFT->RIGHT and RIGHT->LEFT after 64 ticks each; counter 0..63 per state.
REQ-020 sck SHALL be 1 in IDLE, else count[0]; ws SHALL be 1 in IDLE and RIGHT, 0 in LEFT.
REQ-021 Bit MSB-first capture SHALL occur at ticks count=2,4,...,2*SAMPLE_WIDTH of LEFT/RIGHT, sampling sd.
REQ-022 Sample SHALL be complete on the tick leaving LEFT (L) or RIGHT (R); push occurs next clk cycle.
REQ-023 Frame counter SHALL increment (mod 128) on each RIGHT->LEFT transition.
REQ-024 Push when full SHALL drop the new sample and set OVF; pop and push in same cycle when full SHALL succeed without OVF.
REQ-025 EN 1->0 SHALL return FSM to IDLE within 1 cycle, discard partial sample, keep FIFO contents; 0->1 restarts from IDLE count 0.

Reset
REQ-026 rst SHALL asynchronously clear: CTRL, OVF, FIFO pointers (level 0), FSM to IDLE, counters, frame counter, resp=0, rdata=0, irq=0.
REQ-027 While rst or EN=0, sck=1 and ws=1.
REQ-028 FIFO storage SHALL not require reset; contents after reset are unreadable since level is 0.

Configuration
REQ-029 Macro AUDACQ_IRQ_EN defined: irq port present; irq registered = OVF | (WMARK!=0 & level>=WMARK).
REQ-030 AUDACQ_IRQ_EN undefined: no irq port, CTRL[15:8] reads 0, writes to it ignored, all other behaviour identical.

Verification
REQ-031 Reset then read STAT -> resp next cycle, rdata=0x00000200 (EMPTY=1, level 0); sck=1, ws=1.
REQ-032 EN=1 STEREO=1, sd model drives L=0xA5A5A5 R=0x5A5A5A -> after first frame DATA reads 0x00A5A5A5 then 0x805A5A5A.
REQ-033 SAMPLE_WIDTH=16, STEREO=0, L=0x1234 -> DATA=0x00123400, level grows 1 per frame, frame field increments.
REQ-034 FIFO_DEPTH=4, no reads for 5 L+R samples -> level=4, OVF=1, first 4 samples intact; write 0x100 to STAT -> OVF=0.
REQ-035 Write to DATA, addr 0xC, or acc != 4B -> fault=1 same cycle, no resp, state unchanged; rst asserted mid-frame -> all outputs at reset values immediately.
REQ-036 AUDACQ_IRQ_EN, WMARK=3 -> irq=1 the cycle after 3rd push, drops after pop brings level to 2.
